// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, round helpers and controller state encoding
package sha256_pkg;

    typedef enum logic [2:0] {IDLE, CHECK, LOAD, ROUNDS, ACCUM, WRITE, FINISH} state_t;

    // Working variables a..h live at indices 0..7.
    typedef logic [7:0][31:0] hash_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam hash_t H_INIT = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    function automatic logic [31:0] rightrotate(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rightrotate(x, 5'd7) ^ rightrotate(x, 5'd18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rightrotate(x, 5'd17) ^ rightrotate(x, 5'd19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rightrotate(x, 5'd2) ^ rightrotate(x, 5'd13) ^ rightrotate(x, 5'd22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rightrotate(x, 5'd6) ^ rightrotate(x, 5'd11) ^ rightrotate(x, 5'd25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic hash_t sha256_op(input hash_t s, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] t1;
        logic [31:0] t2;
        hash_t r;
        t1 = s[7] + big_sigma1(s[4]) + ch(s[4], s[5], s[6]) + k + w;
        t2 = big_sigma0(s[0]) + maj(s[0], s[1], s[2]);
        r[7:1] = s[6:0];
        r[0] = t1 + t2;
        r[4] = s[3] + t1;
        return r;
    endfunction

endpackage

// File: rtl/sha256_stream_core_wsched.sv
// rtl/sha256_stream_core_wsched.sv - 16-word sliding message schedule window
module sha256_wsched
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        load,
    input  logic        shift,
    input  logic [31:0] w_in,
    output logic [31:0] w_t
);

    // win[0] is the word consumed by the current round; new words enter at win[15].
    logic [31:0] win [16];
    logic [31:0] w_new;

    assign w_new = win[0] + sigma0(win[1]) + win[9] + sigma1(win[14]);
    assign w_t   = win[0];

    always_ff @(posedge clk) begin
        if (load || shift) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i + 1];
            end
            win[15] <= load ? w_in : w_new;
        end
    end

endmodule

// File: rtl/sha256_stream_core.sv
// rtl/sha256_stream_core.sv - multi-block SHA-256 engine with on-chip padding over shared SRAM
module sha256_stream_core
    import sha256_pkg::*;
#(
    parameter int MAX_WORDS = 64,
    parameter int NW_W      = $clog2(MAX_WORDS + 2)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [NW_W-1:0] num_words,
    input  logic [15:0]     message_addr,
    input  logic [15:0]     output_addr,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic            mem_clk,
    output logic            mem_we,
    output logic [15:0]     mem_addr,
    output logic [31:0]     mem_write_data,
    input  logic [31:0]     mem_read_data
);

    state_t state, state_next;

    logic [NW_W-1:0] nw_q;
    logic [15:0]     maddr_q;
    logic [15:0]     oaddr_q;
    logic [11:0]     blk_q;
    logic [4:0]      lcnt;
    logic [5:0]      rnd;
    hash_t           h_q;
    hash_t           work;

    logic [15:0] nw16;
    logic [15:0] nblocks;
    logic [15:0] issue_idx;
    logic [15:0] data_idx;
    logic [31:0] pad_word;
    logic [31:0] w_t;
    logic        wload;
    logic        wshift;
    logic        last_block;
    logic        nw_bad;

    assign mem_clk    = clk;
    assign nw16       = 16'(nw_q);
    assign nblocks    = (nw16 + 16'd18) >> 4;
    assign last_block = ({4'd0, blk_q} == nblocks - 16'd1);
    assign nw_bad     = 32'(nw_q) > 32'(MAX_WORDS);
    // Read issued in load slot lcnt returns two cycles later, so data belongs to slot lcnt-2.
    assign issue_idx  = {blk_q, 4'd0} + 16'(lcnt);
    assign data_idx   = {blk_q, 4'd0} + 16'(lcnt) - 16'd2;

    always_comb begin
        pad_word = 32'd0;
        if (data_idx < nw16) begin
            pad_word = mem_read_data;
        end else if (data_idx == nw16) begin
            pad_word = 32'h8000_0000;
        end else if (data_idx == (nblocks << 4) - 16'd1) begin
            pad_word = {11'd0, nw16, 5'd0};
        end
    end

    sha256_wsched u_wsched (
        .clk   (clk),
        .load  (wload),
        .shift (wshift),
        .w_in  (pad_word),
        .w_t   (w_t)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wload      = 1'b0;
        wshift     = 1'b0;
        case (state)
            IDLE:    if (start) state_next = CHECK;
            CHECK:   state_next = nw_bad ? IDLE : LOAD;
            LOAD: begin
                wload = (lcnt >= 5'd2);
                if (lcnt == 5'd17) state_next = ROUNDS;
            end
            ROUNDS: begin
                wshift = 1'b1;
                if (rnd == 6'd63) state_next = ACCUM;
            end
            ACCUM:   state_next = last_block ? WRITE : LOAD;
            WRITE:   if (lcnt == 5'd7) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= 16'd0;
            mem_write_data <= 32'd0;
            blk_q          <= 12'd0;
            lcnt           <= 5'd0;
            rnd            <= 6'd0;
        end else begin
            done   <= 1'b0;
            error  <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        nw_q    <= num_words;
                        maddr_q <= message_addr;
                        oaddr_q <= output_addr;
                    end
                end
                CHECK: begin
                    if (nw_bad) begin
                        done  <= 1'b1;
                        error <= 1'b1;
                    end else begin
                        busy  <= 1'b1;
                        h_q   <= H_INIT;
                        blk_q <= 12'd0;
                        lcnt  <= 5'd0;
                    end
                end
                LOAD: begin
                    lcnt <= lcnt + 5'd1;
                    if (lcnt < 5'd16 && issue_idx < nw16) begin
                        mem_addr <= maddr_q + issue_idx;
                    end
                    if (lcnt == 5'd17) begin
                        work <= h_q;
                        rnd  <= 6'd0;
                    end
                end
                ROUNDS: begin
                    work <= sha256_op(work, K[rnd], w_t);
                    rnd  <= rnd + 6'd1;
                end
                ACCUM: begin
                    for (int j = 0; j < 8; j++) begin
                        h_q[j] <= h_q[j] + work[j];
                    end
                    lcnt <= 5'd0;
                    if (!last_block) blk_q <= blk_q + 12'd1;
                end
                WRITE: begin
                    mem_we         <= 1'b1;
                    mem_addr       <= oaddr_q + 16'(lcnt);
                    mem_write_data <= h_q[lcnt[2:0]];
                    lcnt           <= lcnt + 5'd1;
                end
                FINISH: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_stream_core.sv
// tb/tb_sha256_stream_core.sv - scoreboard bench for sha256_stream_core with a behavioural SRAM
module tb_sha256_stream_core;
    import sha256_pkg::*;

    localparam int MAX_WORDS = 64;
    localparam int NW_W = $clog2(MAX_WORDS + 2);
    localparam logic [31:0] SENT = 32'hdead_beef;
    localparam logic [255:0] EMPTY_DIGEST =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [NW_W-1:0] num_words = '0;
    logic [15:0]     message_addr = 16'd0;
    logic [15:0]     output_addr = 16'd0;
    logic            busy, done, error, mem_clk, mem_we;
    logic [15:0]     mem_addr;
    logic [31:0]     mem_write_data;
    logic [31:0]     mem_read_data;

    logic [31:0] mem [0:65535];

    typedef struct {
        logic [255:0] dig;
        logic [15:0]  oa;
        int           nw;
        bit           err;
        int           cyc;
        int           t0;
    } item_t;

    item_t q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_count = 0;
    int wr_count = 0;
    bit rd_bad = 1'b0;
    bit busy_seen = 1'b0;
    logic [15:0] rd_base = 16'd0;
    logic [15:0] cur_maddr = 16'd0;

    sha256_stream_core #(.MAX_WORDS(MAX_WORDS), .NW_W(NW_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .num_words      (num_words),
        .message_addr   (message_addr),
        .output_addr    (output_addr),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM: preload once, then one-cycle registered read and synchronous write.
    initial begin
        logic [31:0] s;
        for (int a = 0; a < 65536; a++) mem[a] = SENT;
        s = 32'h0123_4675;
        for (int a = 0; a < MAX_WORDS; a++) begin
            mem[a] = s;
            s = {s[30:0], s[31]};
        end
        for (int a = 0; a < 20; a++) mem[100 + a] = 32'h9e37_79b9 * (a + 1) ^ 32'h5555_0000;
        mem_read_data = 32'd0;
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_addr] <= mem_write_data;
            mem_read_data <= mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] model(input int nw, input logic [15:0] ma);
        logic [31:0] h [8];
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] r;
        int nb, idx;
        nb = (nw + 18) / 16;
        for (int j = 0; j < 8; j++) h[j] = H_INIT[j];
        for (int b = 0; b < nb; b++) begin
            for (int t = 0; t < 16; t++) begin
                idx = b * 16 + t;
                if (idx < nw) w[t] = mem[ma + 16'(idx)];
                else if (idx == nw) w[t] = 32'h8000_0000;
                else if (idx == 16 * nb - 1) w[t] = 32'(nw * 32);
                else w[t] = 32'd0;
            end
            for (int t = 16; t < 64; t++) begin
                s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = w[t-16] + s0 + w[t-7] + s1;
            end
            for (int j = 0; j < 8; j++) v[j] = h[j];
            for (int t = 0; t < 64; t++) begin
                t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
                t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
                   + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                for (int j = 7; j > 0; j--) v[j] = v[j-1];
                v[4] = v[4] + t1;
                v[0] = t1 + t2;
            end
            for (int j = 0; j < 8; j++) h[j] = h[j] + v[j];
        end
        for (int j = 0; j < 8; j++) r[255 - 32*j -: 32] = h[j];
        return r;
    endfunction

    // Monitor: per-job read/write tracking, pops the scoreboard on every done.
    initial begin
        logic prev_busy;
        logic [15:0] prev_addr;
        logic [255:0] got;
        item_t it;
        prev_busy = 1'b0;
        prev_addr = 16'd0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (busy && !prev_busy) begin
                    rd_count = 0;
                    rd_bad   = 1'b0;
                    rd_base  = cur_maddr;
                end
                if (busy && !mem_we && mem_addr !== prev_addr) begin
                    if (mem_addr !== rd_base + 16'(rd_count)) rd_bad = 1'b1;
                    rd_count++;
                end
                if (mem_we) wr_count++;
                if (busy) busy_seen = 1'b1;
                if (done) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 with no job pending, required none");
                    end else begin
                        it = q.pop_front();
                        check("error_flag", 256'(error), 256'(it.err));
                        check("cycles", 256'(cyc - it.t0), 256'(it.cyc));
                        check("writes", 256'(wr_count), it.err ? 256'd0 : 256'd8);
                        if (it.err) begin
                            check("busy_never", 256'(busy_seen), 256'd0);
                        end else begin
                            check("reads", 256'(rd_count), 256'(it.nw));
                            check("read_addr_seq", 256'(rd_bad), 256'd0);
                            for (int j = 0; j < 8; j++) got[255 - 32*j -: 32] = mem[it.oa + 16'(j)];
                            check("digest", got, it.dig);
                        end
                    end
                    wr_count  = 0;
                    busy_seen = 1'b0;
                end
            end
            prev_busy = busy;
            prev_addr = mem_addr;
        end
    end

    task automatic issue(input int nw, input logic [15:0] ma, input logic [15:0] oa,
                         input bit err, input int exp_cyc, input logic [255:0] dig);
        item_t it;
        num_words    = NW_W'(nw);
        message_addr = ma;
        output_addr  = oa;
        cur_maddr    = ma;
        it.dig = dig;
        it.oa  = oa;
        it.nw  = nw;
        it.err = err;
        it.cyc = exp_cyc;
        it.t0  = cyc;
        q.push_back(it);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d jobs pending after %0d cycles, required 0", q.size(), n);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 256'(busy), 256'd0);
        check({tag, "_done"}, 256'(done), 256'd0);
        check({tag, "_error"}, 256'(error), 256'd0);
        check({tag, "_mem_we"}, 256'(mem_we), 256'd0);
        check({tag, "_mem_addr"}, 256'(mem_addr), 256'd0);
        check({tag, "_mem_wdata"}, 256'(mem_write_data), 256'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        @(negedge clk);

        issue(0, 16'd0, 16'd1000, 1'b0, 94, EMPTY_DIGEST);
        wait_done();

        issue(20, 16'd0, 16'd500, 1'b0, 177, model(20, 16'd0));
        wait_done();

        issue(13, 16'd0, 16'd520, 1'b0, 94, model(13, 16'd0));
        wait_done();
        issue(14, 16'd0, 16'd540, 1'b0, 177, model(14, 16'd0));
        wait_done();

        issue(5, 16'd0, 16'd600, 1'b0, 94, model(5, 16'd0));
        repeat (30) @(negedge clk);
        output_addr = 16'd3000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check("ignored_start_untouched", 256'(mem[3000]), 256'(SENT));
        issue(3, 16'd0, 16'd2000, 1'b0, 94, model(3, 16'd0));
        wait_done();

        num_words    = NW_W'(20);
        message_addr = 16'd0;
        output_addr  = 16'd800;
        cur_maddr    = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (119) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        reset_n = 1'b1;
        w0 = wr_count;
        repeat (200) @(negedge clk);
        check("abort_no_writes", 256'(wr_count), 256'(w0));
        check("abort_digest_untouched", 256'(mem[800]), 256'(SENT));
        issue(17, 16'd100, 16'd700, 1'b0, 177, model(17, 16'd100));
        wait_done();

        issue(MAX_WORDS + 1, 16'd0, 16'd900, 1'b1, 2, 256'd0);
        wait_done();
        check("reject_no_write", 256'(mem[900]), 256'(SENT));
        issue(MAX_WORDS, 16'd0, 16'd1100, 1'b0, 426, model(MAX_WORDS, 16'd0));
        wait_done();

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
